// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: word, RAM status and arbiter state types shared by the caches, RAM model and arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: per-core icache/dcache request bundle plus the shared RAM port.
// Latency: n/a (wires only).
// Backpressure: *wait outputs stall each cache port; ramstate stalls the arbiter.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
);
  // cache side
  logic  [CPUS-1:0] iREN;
  word_t [CPUS-1:0] iaddr;
  logic  [CPUS-1:0] dREN;
  logic  [CPUS-1:0] dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic  [CPUS-1:0] iwait;
  logic  [CPUS-1:0] dwait;
  word_t [CPUS-1:0] iload;
  word_t [CPUS-1:0] dload;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      arb_err;

  // caches + RAM model
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  // arbiter
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first active request at or after the pointer, wrapping modulo CPUS.
// Latency: combinational.
// Backpressure: none; o_gnt is all-zero when no request is active.
module rr_pick #(
  parameter int CPUS = 2,
  parameter int IW   = 1
) (
  input  logic [CPUS-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [CPUS-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);
  logic [IW:0] w_pos;
  logic        w_found;

  // Scan CPUS slots starting at the pointer; the first active one wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < CPUS; k++) begin
      w_pos = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(CPUS)) w_pos = w_pos - (IW+1)'(CPUS);
      if (!w_found && i_req[w_pos[IW-1:0]]) begin
        w_found               = 1'b1;
        o_gnt[w_pos[IW-1:0]]  = 1'b1;
        o_idx                 = w_pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one RAM port shared by CPUS icache/dcache pairs; data beats instruction, one grant held until done.
// Latency: request seen in IDLE is granted next cycle; wait released combinationally on ACCESS/ERROR; one IDLE cycle between grants.
// Backpressure: every requesting port sees *wait=1 until its own completion. Build option MEM_ARB_RR_EN: round-robin per class, else fixed priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t       r_state;
  logic [IW-1:0]    r_gnt;
  logic [CPUS-1:0]  w_dreq;
  logic [CPUS-1:0]  w_dgnt_oh;
  logic [CPUS-1:0]  w_ignt_oh;
  logic [IW-1:0]    w_dptr;
  logic [IW-1:0]    w_iptr;
  logic [IW-1:0]    w_didx;
  logic [IW-1:0]    w_iidx;
  logic             w_gnt_en;
  logic             w_done;
  logic             w_err;
  logic [CPUS-1:0]  w_iwait;
  logic [CPUS-1:0]  w_dwait;
  word_t [CPUS-1:0] w_iload;
  word_t [CPUS-1:0] w_dload;
  logic             w_ren;
  logic             w_wen;
  word_t            w_addr;
  word_t            w_store;

  assign w_dreq = bus.dREN | bus.dWEN;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] r_dptr;
  logic [IW-1:0] r_iptr;
  logic [IW-1:0] w_gnt_nxt;

  assign w_gnt_nxt = (r_gnt == IW'(CPUS-1)) ? '0 : r_gnt + 1'b1;

  // Move the granted class's pointer past the winner, only when the access completes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dptr <= '0;
      r_iptr <= '0;
    end else if (w_done) begin
      if (r_state == DGRANT) r_dptr <= w_gnt_nxt;
      else                   r_iptr <= w_gnt_nxt;
    end
  end

  assign w_dptr = r_dptr;
  assign w_iptr = r_iptr;
`else
  // Fixed priority: the search always starts at core 0
  assign w_dptr = '0;
  assign w_iptr = '0;
`endif

  rr_pick #(.CPUS(CPUS), .IW(IW)) u_dpick (
    .i_req (w_dreq),
    .i_ptr (w_dptr),
    .o_gnt (w_dgnt_oh),
    .o_idx (w_didx)
  );

  rr_pick #(.CPUS(CPUS), .IW(IW)) u_ipick (
    .i_req (bus.iREN),
    .i_ptr (w_iptr),
    .o_gnt (w_ignt_oh),
    .o_idx (w_iidx)
  );

  // Is the granted core still asking for the access it was granted
  always_comb begin
    w_gnt_en = 1'b0;
    case (r_state)
      DGRANT:  w_gnt_en = w_dreq[r_gnt];
      IGRANT:  w_gnt_en = bus.iREN[r_gnt];
      default: w_gnt_en = 1'b0;
    endcase
  end

  assign w_done = w_gnt_en && (bus.ramstate == ACCESS || bus.ramstate == ERROR);
  assign w_err  = w_gnt_en && (bus.ramstate == ERROR);

  // Grant FSM: pick d before i in IDLE, leave a grant on completion or withdrawal
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_dgnt_oh) begin
            r_state <= DGRANT;
            r_gnt   <= w_didx;
          end else if (|w_ignt_oh) begin
            r_state <= IGRANT;
            r_gnt   <= w_iidx;
          end
        end
        default: begin
          if (!w_gnt_en || w_done) r_state <= IDLE;
        end
      endcase
    end
  end

  // Steer the granted core onto the RAM and release only its wait on completion
  always_comb begin
    w_ren   = 1'b0;
    w_wen   = 1'b0;
    w_addr  = '0;
    w_store = '0;
    w_iwait = bus.iREN;
    w_dwait = w_dreq;
    w_iload = '0;
    w_dload = '0;
    case (r_state)
      DGRANT: begin
        w_wen   = bus.dWEN[r_gnt];
        w_ren   = bus.dREN[r_gnt] & ~bus.dWEN[r_gnt];
        w_addr  = bus.daddr[r_gnt];
        w_store = bus.dstore[r_gnt];
        if (w_done) begin
          w_dwait[r_gnt] = 1'b0;
          w_dload[r_gnt] = w_err ? '0 : bus.ramload;
        end
      end
      IGRANT: begin
        w_ren  = bus.iREN[r_gnt];
        w_addr = bus.iaddr[r_gnt];
        if (w_done) begin
          w_iwait[r_gnt] = 1'b0;
          w_iload[r_gnt] = w_err ? '0 : bus.ramload;
        end
      end
      default: ;
    endcase
  end

  assign bus.ramREN   = w_ren;
  assign bus.ramWEN   = w_wen;
  assign bus.ramaddr  = w_addr;
  assign bus.ramstore = w_store;
  assign bus.iwait    = w_iwait;
  assign bus.dwait    = w_dwait;
  assign bus.iload    = w_iload;
  assign bus.dload    = w_dload;
  assign bus.arb_err  = w_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios then random traffic, every cycle compared against a request-level model.
// Latency: model grants one cycle after a request is seen idle, releases on ACCESS/ERROR.
// Backpressure: model expects wait=1 on every requesting port except the completing one.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  mem_arbiter_if #(.CPUS(CPUS)) bus ();

  mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // reference model: who owns the RAM (-1 = nobody), which class, per-class pointers
  int m_owner = -1;
  int m_cls   = 0;   // 0 = data, 1 = instruction
  int m_dptr  = 0;
  int m_iptr  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [CPUS-1:0] req, input int ptr);
    for (int k = 0; k < CPUS; k++) begin
      if (req[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
    end
    return -1;
  endfunction

  function automatic logic owner_en();
    if (m_owner < 0) return 1'b0;
    if (m_cls == 0)  return bus.dREN[m_owner] | bus.dWEN[m_owner];
    return bus.iREN[m_owner];
  endfunction

  function automatic logic owner_done();
    return owner_en() && (bus.ramstate == ACCESS || bus.ramstate == ERROR);
  endfunction

  // settle, then compare every output with what the model says for this cycle
  task automatic look(input string tag);
    logic [CPUS-1:0] e_iwait, e_dwait;
    word_t e_iload [CPUS];
    word_t e_dload [CPUS];
    logic  e_ren, e_wen, e_err;
    word_t e_addr, e_store;
    #1;
    e_iwait = bus.iREN;
    e_dwait = bus.dREN | bus.dWEN;
    for (int c = 0; c < CPUS; c++) begin
      e_iload[c] = '0;
      e_dload[c] = '0;
    end
    e_ren = 1'b0; e_wen = 1'b0; e_err = 1'b0; e_addr = '0; e_store = '0;
    if (m_owner >= 0) begin
      if (m_cls == 0) begin
        e_wen   = bus.dWEN[m_owner];
        e_ren   = bus.dREN[m_owner] && !bus.dWEN[m_owner];
        e_addr  = bus.daddr[m_owner];
        e_store = bus.dstore[m_owner];
      end else begin
        e_ren  = bus.iREN[m_owner];
        e_addr = bus.iaddr[m_owner];
      end
      if (owner_done()) begin
        e_err = (bus.ramstate == ERROR);
        if (m_cls == 0) begin
          e_dwait[m_owner] = 1'b0;
          e_dload[m_owner] = e_err ? 32'h0 : bus.ramload;
        end else begin
          e_iwait[m_owner] = 1'b0;
          e_iload[m_owner] = e_err ? 32'h0 : bus.ramload;
        end
      end
    end
    chk({tag, ".ramREN"},   32'(bus.ramREN),  32'(e_ren));
    chk({tag, ".ramWEN"},   32'(bus.ramWEN),  32'(e_wen));
    chk({tag, ".ramaddr"},  bus.ramaddr,      e_addr);
    chk({tag, ".ramstore"}, bus.ramstore,     e_store);
    chk({tag, ".arb_err"},  32'(bus.arb_err), 32'(e_err));
    chk({tag, ".iwait"},    32'(bus.iwait),   32'(e_iwait));
    chk({tag, ".dwait"},    32'(bus.dwait),   32'(e_dwait));
    for (int c = 0; c < CPUS; c++) begin
      chk($sformatf("%s.iload%0d", tag, c), bus.iload[c], e_iload[c]);
      chk($sformatf("%s.dload%0d", tag, c), bus.dload[c], e_dload[c]);
    end
  endtask

  // apply the request-level rules across one rising edge
  task automatic clk_edge();
    logic [CPUS-1:0] dreq;
    int n_owner, n_cls;
    dreq    = bus.dREN | bus.dWEN;
    n_owner = m_owner;
    n_cls   = m_cls;
    if (m_owner < 0) begin
      if (dreq != '0) begin
        n_owner = pick(dreq, m_dptr);
        n_cls   = 0;
      end else if (bus.iREN != '0) begin
        n_owner = pick(bus.iREN, m_iptr);
        n_cls   = 1;
      end
    end else if (owner_done()) begin
      n_owner = -1;
`ifdef MEM_ARB_RR_EN
      if (m_cls == 0) m_dptr = (m_owner + 1) % CPUS;
      else            m_iptr = (m_owner + 1) % CPUS;
`endif
    end else if (!owner_en()) begin
      n_owner = -1;
    end
    @(posedge CLK);
    m_owner = n_owner;
    m_cls   = n_cls;
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

  int exp_order [4];
  int winner;

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    look("rst");
    RST = 1'b0;

    // T1: single instruction fetch, BUSY BUSY ACCESS
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h0000_0040; bus.ramload = 32'hDEAD_BEEF;
    bus.ramstate = BUSY;
    look("t1_c0"); clk_edge();
    look("t1_c1");
    chk("t1_ren_c1", 32'(bus.ramREN), 32'd1);
    chk("t1_addr_c1", bus.ramaddr, 32'h0000_0040);
    chk("t1_iwait_c1", 32'(bus.iwait[0]), 32'd1);
    clk_edge();
    look("t1_c2"); clk_edge();
    bus.ramstate = ACCESS;
    look("t1_c3");
    chk("t1_iwait_rel", 32'(bus.iwait[0]), 32'd0);
    chk("t1_iload", bus.iload[0], 32'hDEAD_BEEF);
    clk_edge();
    bus.iREN[0] = 1'b0; bus.ramstate = FREE;

    // T2: dWEN[1] and iREN[1] together; d first, then one idle cycle, then i
    bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h0000_1000; bus.dstore[1] = 32'hCAFE_0001;
    bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h0000_2000; bus.ramload = 32'h1234_5678;
    look("t2_c0"); clk_edge();
    bus.ramstate = BUSY;
    look("t2_c1");
    chk("t2_wen", 32'(bus.ramWEN), 32'd1);
    chk("t2_ren", 32'(bus.ramREN), 32'd0);
    chk("t2_store", bus.ramstore, 32'hCAFE_0001);
    clk_edge();
    bus.ramstate = ACCESS;
    look("t2_c2");
    chk("t2_dwait_rel", 32'(bus.dwait[1]), 32'd0);
    clk_edge();
    bus.dWEN[1] = 1'b0; bus.ramstate = FREE;
    look("t2_gap");
    chk("t2_gap_en", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    clk_edge();
    bus.ramstate = ACCESS;
    look("t2_i");
    chk("t2_i_addr", bus.ramaddr, 32'h0000_2000);
    chk("t2_i_load", bus.iload[1], 32'h1234_5678);
    clk_edge();
    bus.iREN[1] = 1'b0; bus.ramstate = FREE;

    // T3: both dcaches reading, four back-to-back completions
    bus.dREN = 2'b11; bus.daddr[0] = 32'h100; bus.daddr[1] = 32'h200; bus.ramstate = ACCESS;
    for (int n = 0; n < 4; n++) begin
      look($sformatf("t3_idle%0d", n)); clk_edge();
      look($sformatf("t3_gnt%0d", n));
      winner = (bus.dwait[0] == 1'b0) ? 0 : (bus.dwait[1] == 1'b0) ? 1 : -1;
      chk($sformatf("t3_order%0d", n), 32'(winner), 32'(exp_order[n]));
      clk_edge();
    end
    bus.dREN = '0; bus.ramstate = FREE;

    // T4: ERROR completes a data read with zero load and an error pulse
    bus.dREN[0] = 1'b1; bus.ramload = 32'hFFFF_0000;
    look("t4_c0"); clk_edge();
    bus.ramstate = ERROR;
    look("t4_c1");
    chk("t4_dwait", 32'(bus.dwait[0]), 32'd0);
    chk("t4_dload", bus.dload[0], 32'd0);
    chk("t4_err", 32'(bus.arb_err), 32'd1);
    clk_edge();
    bus.dREN[0] = 1'b0; bus.ramstate = FREE;
    look("t4_c2");
    chk("t4_err_gone", 32'(bus.arb_err), 32'd0);
    chk("t4_idle", 32'(bus.ramREN), 32'd0);
    clk_edge();

    // T5: iREN[0] withdrawn in the second BUSY cycle; pointer must not move
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h300; bus.iaddr[1] = 32'h400; bus.ramstate = BUSY;
    look("t5_c0"); clk_edge();
    look("t5_c1");
    chk("t5_iwait_held", 32'(bus.iwait[0]), 32'd1);
    clk_edge();
    bus.iREN[0] = 1'b0;
    look("t5_c2"); clk_edge();
    bus.iREN = 2'b11; bus.ramstate = ACCESS;
    look("t5_c3");
    chk("t5_idle", 32'(bus.ramREN), 32'd0);
    clk_edge();
    look("t5_c4");
    chk("t5_regrant_addr", bus.ramaddr, 32'h300);
    clk_edge();
    bus.iREN = '0; bus.ramstate = FREE;

    // T6: reset in the middle of a grant
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h500; bus.ramstate = BUSY;
    look("t6_c0"); clk_edge();
    look("t6_c1");
    chk("t6_ren_before", 32'(bus.ramREN), 32'd1);
    RST = 1'b1;
    #1;
    chk("t6_ren_async", 32'(bus.ramREN), 32'd0);
    m_owner = -1; m_dptr = 0; m_iptr = 0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    look("t6_c2"); clk_edge();
    bus.ramstate = ACCESS;
    look("t6_c3");
    chk("t6_regrant", 32'(bus.ramREN), 32'd1);
    chk("t6_addr", bus.ramaddr, 32'h500);
    clk_edge();
    bus.dREN[1] = 1'b0; bus.ramstate = FREE;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 3) == 0) bus.iREN[c] = ~bus.iREN[c];
        if ($urandom_range(0, 3) == 0) bus.dREN[c] = ~bus.dREN[c];
        if ($urandom_range(0, 7) == 0) bus.dWEN[c] = ~bus.dWEN[c];
        bus.iaddr[c]  = $urandom();
        bus.daddr[c]  = $urandom();
        bus.dstore[c] = $urandom();
      end
      bus.ramload  = $urandom();
      bus.ramstate = ramstate_t'($urandom_range(0, 3));
      look($sformatf("rnd%0d", i));
      clk_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
